// File: rtl/freq_meter_pkg.sv
// Shared types, range constants and gate-length helper for the frequency meter.
// A range r selects a gate of CLK_HZ / 10^r system clock cycles.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClr,
      StGate,
      StLatch
   } state_e;

   localparam logic [1:0] RNG_1S    = 2'd0;
   localparam logic [1:0] RNG_100MS = 2'd1;
   localparam logic [1:0] RNG_10MS  = 2'd2;

   function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] rng);
      case (rng)
         RNG_1S:    return clk_hz;
         RNG_100MS: return clk_hz / 10;
         default:   return clk_hz / 100;
      endcase
   endfunction

   function automatic logic [1:0] clamp_rng(input logic [1:0] rng);
      return (rng == 2'd3) ? RNG_10MS : rng;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD event counter with synchronous clear and a sticky carry-out flag.
// The count keeps wrapping after overflow; the flag stays set until the next clear.
module bcd_counter #(
   parameter int unsigned DIGITS = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic                inc_i,
   output logic [4*DIGITS-1:0] count_o,
   output logic                ovf_o
);

   logic [4*DIGITS-1:0] count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                carry;

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      carry   = 1'b0;
      if (clr_i) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (en_i && inc_i) begin
         carry = 1'b1;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
               if (count_q[4*i +: 4] == 4'd9) begin
                  count_d[4*i +: 4] = 4'd0;
               end else begin
                  count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  carry             = 1'b0;
               end
            end
         end
         if (carry) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/freq_meter_ctrl.sv
// Frequency-meter sequencer: synchronises sig_in, counts its rising edges over a
// clock-derived gate window and latches the BCD result with its range tag.
module freq_meter_ctrl
   import freq_meter_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned DIGITS = 8
) (
   input  logic                iCLK,
   input  logic                reset,
   input  logic                sig_in,
   input  logic                start,
   input  logic                cont,
   input  logic                auto_rng,
   input  logic [1:0]          rng_sel,
   output logic                busy,
   output logic                valid,
   output logic [4*DIGITS-1:0] ofreqnum,
   output logic [1:0]          orange,
   output logic                ovf
);

   localparam int unsigned         TimerW   = $clog2(CLK_HZ);
   localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

   state_e              state_q, state_d;
   logic [2:0]          sync_q, sync_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [1:0]          wrng_q, wrng_d;
   logic [1:0]          arng_q, arng_d;
   logic [1:0]          arng_nx;
   logic [4*DIGITS-1:0] freq_q, freq_d;
   logic [1:0]          orng_q, orng_d;
   logic                ovf_q, ovf_d;
   logic                valid_q, valid_d;

   logic                sig_rise;
   logic                cnt_clr;
   logic                cnt_en;
   logic [4*DIGITS-1:0] cnt;
   logic                cnt_ovf;

   assign sync_d   = {sync_q[1:0], sig_in};
   assign sig_rise = sync_q[1] & ~sync_q[2];

   bcd_counter #(
      .DIGITS(DIGITS)
   ) u_bcd_counter (
      .clk_i  (iCLK),
      .rst_ni (reset),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .inc_i  (sig_rise),
      .count_o(cnt),
      .ovf_o  (cnt_ovf)
   );

   // Auto range steps up on overflow and down when the top digit is unused.
   always_comb begin
      arng_nx = arng_q;
      if (cnt_ovf && (arng_q < RNG_10MS)) begin
         arng_nx = arng_q + 2'd1;
      end else if (!cnt_ovf && (cnt[4*DIGITS-1 -: 4] == 4'd0) && (arng_q != RNG_1S)) begin
         arng_nx = arng_q - 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      wrng_d  = wrng_q;
      arng_d  = arng_q;
      freq_d  = freq_q;
      orng_d  = orng_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start || cont) begin
               state_d = StClr;
               wrng_d  = auto_rng ? arng_q : clamp_rng(rng_sel);
            end
         end
         StClr: begin
            cnt_clr = 1'b0 | 1'b1;
            timer_d = TimerW'(gate_len(CLK_HZ, wrng_q) - 32'd1);
            state_d = StGate;
         end
         StGate: begin
            cnt_en = 1'b1;
            if (timer_q == '0) begin
               state_d = StLatch;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StLatch: begin
            freq_d  = cnt_ovf ? AllNines : cnt;
            ovf_d   = cnt_ovf;
            orng_d  = wrng_q;
            valid_d = 1'b1;
            arng_d  = arng_nx;
            if (cont) begin
               state_d = StClr;
               wrng_d  = auto_rng ? arng_nx : clamp_rng(rng_sel);
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!reset) begin
         state_q <= StIdle;
         sync_q  <= '0;
         timer_q <= '0;
         wrng_q  <= RNG_1S;
         arng_q  <= RNG_1S;
         freq_q  <= '0;
         orng_q  <= RNG_1S;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         timer_q <= timer_d;
         wrng_q  <= wrng_d;
         arng_q  <= arng_d;
         freq_q  <= freq_d;
         orng_q  <= orng_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign valid    = valid_q;
   assign ofreqnum = freq_q;
   assign orange   = orng_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Self-checking bench for freq_meter_ctrl: directed table, hand-written corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_freq_meter_ctrl;

   localparam int unsigned ClkHz = 1000;
   localparam int unsigned DigA  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, sig, start, cont, auto_a, cont_b, auto_b;
   logic [1:0] rng_sel;
   logic       busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
   logic [31:0] freq_a;
   logic [7:0]  freq_b;
   logic [1:0]  orng_a, orng_b;

   int checks = 0;
   int errors = 0;

   freq_meter_ctrl #(.CLK_HZ(ClkHz), .DIGITS(DigA)) u_dut_a (
      .iCLK(clk), .reset(rst_n), .sig_in(sig), .start(start), .cont(cont),
      .auto_rng(auto_a), .rng_sel(rng_sel), .busy(busy_a), .valid(valid_a),
      .ofreqnum(freq_a), .orange(orng_a), .ovf(ovf_a)
   );

   freq_meter_ctrl #(.CLK_HZ(ClkHz), .DIGITS(2)) u_dut_b (
      .iCLK(clk), .reset(rst_n), .sig_in(sig), .start(1'b0), .cont(cont_b),
      .auto_rng(auto_b), .rng_sel(2'd0), .busy(busy_b), .valid(valid_b),
      .ofreqnum(freq_b), .orange(orng_b), .ovf(ovf_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned gate_of(input int unsigned r);
      return (r == 0) ? ClkHz : (r == 1) ? ClkHz / 10 : ClkHz / 100;
   endfunction

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Signal source: 0 = constant low, 1 = square wave of sig_per cycles, 2 = random.
   int sig_mode = 0;
   int sig_per  = 2;
   int ph       = 0;
   always @(negedge clk) begin
      if (sig_mode == 1 && sig_per > 0) begin
         ph  = (ph + 1) % sig_per;
         sig = (ph < sig_per / 2);
      end else if (sig_mode == 2) begin
         sig = 1'($urandom_range(0, 1));
      end else begin
         sig = 1'b0;
      end
   end

   // Reference model for DUT A: a measurement accepted at edge k latches at edge k+G+2 and
   // counts rising edges of the sampled input seen during cycles following edges k+1..k+G.
   int unsigned e = 0;
   bit          hist [0:65535];
   bit          m_active = 0;
   int unsigned m_k = 0, m_rng = 0, m_auto = 0, m_valid_e = 0;
   logic [31:0] m_freq = '0;
   int unsigned m_orng = 0;
   bit          m_ovf = 0;

   always @(posedge clk) begin
      int unsigned g, cnt, wrapped, lim;
      e++;
      hist[e % 65536] = sig;
      if (!rst_n) begin
         hist[e % 65536] = 1'b0;
         m_active = 0; m_auto = 0; m_freq = '0; m_orng = 0; m_ovf = 0;
      end else if (!m_active) begin
         if (start || cont) begin
            m_active = 1;
            m_k      = e;
            m_rng    = auto_a ? m_auto : ((rng_sel == 3) ? 2 : int'(rng_sel));
         end
      end else begin
         g = gate_of(m_rng);
         if (e == m_k + g + 2) begin
            cnt = 0;
            for (int unsigned x = m_k + 1; x <= m_k + g; x++)
               if (hist[(x - 1) % 65536] && !hist[(x - 2) % 65536]) cnt++;
            lim     = 100000000;
            m_ovf   = (cnt >= lim);
            wrapped = cnt % lim;
            m_freq  = m_ovf ? 32'h99999999 : to_bcd(wrapped);
            m_orng  = m_rng;
            if (m_ovf && m_auto < 2) m_auto = m_auto + 1;
            else if (!m_ovf && (wrapped / 10000000) == 0 && m_auto > 0) m_auto = m_auto - 1;
            m_valid_e = e;
            if (cont) begin
               m_k   = e;
               m_rng = auto_a ? m_auto : ((rng_sel == 3) ? 2 : int'(rng_sel));
            end else begin
               m_active = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_busy", busy_a, m_active);
      chk("model_valid", valid_a, (m_valid_e == e));
      chk("model_freq", freq_a, m_freq);
      chk("model_orange", orng_a, m_orng);
      chk("model_ovf", ovf_a, m_ovf);
   end

   typedef struct {
      logic [1:0]  rng;
      int          per;
      logic [31:0] exp_freq;
      logic [1:0]  exp_rng;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   vec_t vecs [5];

   task automatic wait_valid(input bit on_b, input int budget, output int lat);
      lat = 0;
      while (!(on_b ? valid_b : valid_a) && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= budget) chk(on_b ? "timeout_valid_b" : "timeout_valid_a", 32'd0, 32'd1);
   endtask

   task automatic count_valid(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (valid_a) n++;
      end
   endtask

   initial begin
      int lat, n;
      vecs[0] = '{2'd0, 10, 32'h00000100, 2'd0, 1'b0, 1002};
      vecs[1] = '{2'd3,  2, 32'h00000005, 2'd2, 1'b0, 12};
      vecs[2] = '{2'd1,  4, 32'h00000025, 2'd1, 1'b0, 102};
      vecs[3] = '{2'd2,  5, 32'h00000002, 2'd2, 1'b0, 12};
      vecs[4] = '{2'd1,  0, 32'h00000000, 2'd1, 1'b0, 102};

      rst_n = 1'b0; start = 1'b0; cont = 1'b0; auto_a = 1'b0; rng_sel = 2'd0;
      cont_b = 1'b0; auto_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_busy", busy_a, 1'b0);
      chk("reset_freq", freq_a, 32'd0);
      chk("reset_freq_b", freq_b, 32'd0);

      // Directed single-shot table.
      for (int i = 0; i < 5; i++) begin
         sig_mode = (vecs[i].per > 0) ? 1 : 0;
         sig_per  = vecs[i].per;
         rng_sel  = vecs[i].rng;
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_valid(1'b0, 1100, lat);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_freq", i), freq_a, vecs[i].exp_freq);
         chk($sformatf("vec%0d_orange", i), orng_a, vecs[i].exp_rng);
         chk($sformatf("vec%0d_ovf", i), ovf_a, vecs[i].exp_ovf);
         @(negedge clk);
         chk($sformatf("vec%0d_busy_after", i), busy_a, 1'b0);
         chk($sformatf("vec%0d_valid_1cyc", i), valid_a, 1'b0);
      end

      // Two-digit instance: overflow, auto range up, then steady.
      sig_mode = 1; sig_per = 4;
      cont_b = 1'b1;
      wait_valid(1'b1, 1100, lat);
      chk("b1_freq", freq_b, 32'h99);
      chk("b1_ovf", ovf_b, 1'b1);
      chk("b1_orange", orng_b, 2'd0);
      @(negedge clk);
      wait_valid(1'b1, 200, lat);
      chk("b2_freq", freq_b, 32'h25);
      chk("b2_ovf", ovf_b, 1'b0);
      chk("b2_orange", orng_b, 2'd1);
      @(negedge clk);
      wait_valid(1'b1, 200, lat);
      chk("b3_freq", freq_b, 32'h25);
      chk("b3_orange", orng_b, 2'd1);
      cont_b = 1'b0;
      lat = 0;
      while (busy_b && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("b_idle", busy_b, 1'b0);

      // Continuous mode spacing, then drop cont mid-gate.
      sig_mode = 0; rng_sel = 2'd2; cont = 1'b1;
      wait_valid(1'b0, 50, lat);
      for (int r = 0; r < 2; r++) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!valid_a && lat < 50);
         chk($sformatf("cont_spacing%0d", r), lat, 12);
         chk($sformatf("cont_freq%0d", r), freq_a, 32'd0);
      end
      repeat (4) @(negedge clk);
      cont = 1'b0;
      count_valid(40, n);
      chk("cont_drop_valids", n, 1);
      chk("cont_drop_busy", busy_a, 1'b0);

      // Reset mid-gate aborts the measurement.
      sig_mode = 1; sig_per = 2; rng_sel = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid_busy", busy_a, 1'b0);
      chk("rst_mid_freq", freq_a, 32'd0);
      chk("rst_mid_orange", orng_a, 2'd0);
      chk("rst_mid_ovf", ovf_a, 1'b0);
      count_valid(150, n);
      chk("rst_mid_no_valid", n, 0);

      // Start and rng_sel changes while busy are ignored.
      rng_sel = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; rng_sel = 2'd0;
      @(negedge clk);
      start = 1'b0;
      wait_valid(1'b0, 50, lat);
      chk("busy_start_orange", orng_a, 2'd2);
      chk("busy_start_freq", freq_a, 32'h5);
      @(negedge clk);
      chk("busy_start_idle", busy_a, 1'b0);
      count_valid(30, n);
      chk("busy_start_extra_valid", n, 0);

      // Randomized traffic, checked by the reference model every cycle.
      sig_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start   = ($urandom_range(0, 19) == 0);
         rng_sel = ($urandom_range(0, 49) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         if ($urandom_range(0, 199) == 0) cont = ~cont;
         if ($urandom_range(0, 299) == 0) auto_a = ~auto_a;
      end
      start = 1'b0; cont = 1'b0;
      lat = 0;
      while (busy_a && lat < 1100) begin
         @(negedge clk);
         lat++;
      end
      chk("final_idle", busy_a, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
